fdiv_seq: RTL and testbench

FDIV_SEQ -- requirements
Module: fdiv_seq

---
 rtl/fdiv_seq.sv | 137 +++++++++++++
 tb/tb_fdiv_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, truncating rounding, valid/ready handshakes on both sides.
module fdiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] y
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic        [4:0]  cnt_q,   cnt_d;
  logic        [24:0] rem_q,   rem_d;
  logic        [23:0] quo_q,   quo_d;
  logic        [23:0] div_q,   div_d;
  logic signed [9:0]  ediff_q, ediff_d;
  logic               sign_q,  sign_d;
  logic        [31:0] y_q,     y_d;

  logic               rem_ge;
  logic        [23:0] rem_sub;
  logic        [24:0] q_full;
  logic signed [9:0]  e_res;
  logic        [22:0] man_res;
  logic        [31:0] norm_y;
  logic               acc_sign;

  // One restoring step plus the normalisation of the finished quotient.
  always_comb begin
    rem_ge  = rem_q >= {1'b0, div_q};
    // rem < 2B always holds, so the difference fits in 24 bits when rem >= B.
    rem_sub = rem_q[23:0] - div_q;
    q_full  = {quo_q, rem_ge};
    if (q_full[24]) begin
      man_res = q_full[23:1];
      e_res   = ediff_q + 10'sd127;
    end else begin
      man_res = q_full[22:0];
      e_res   = ediff_q + 10'sd126;
    end
    if (e_res <= 10'sd0) begin
      norm_y = {sign_q, 31'h0};
    end else if (e_res >= 10'sd255) begin
      norm_y = {sign_q, 8'hFF, 23'h0};
    end else begin
      norm_y = {sign_q, e_res[7:0], man_res};
    end
  end

  assign acc_sign = x1[31] ^ x2[31];

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    ediff_d = ediff_q;
    sign_d  = sign_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sign_d = acc_sign;
          if (x2[30:23] == 8'h00) begin
            y_d     = {acc_sign, 8'hFF, 23'h0};
            state_d = S_DONE;
          end else if (x1[30:23] == 8'h00) begin
            y_d     = {acc_sign, 31'h0};
            state_d = S_DONE;
          end else begin
            rem_d   = {2'b01, x1[22:0]};
            div_d   = {1'b1, x2[22:0]};
            quo_d   = '0;
            cnt_d   = 5'd24;
            ediff_d = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]});
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? {rem_sub, 1'b0} : {rem_q[23:0], 1'b0};
        quo_d = q_full[23:0];
        if (cnt_q == 5'd0) begin
          y_d     = norm_y;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      ediff_q <= '0;
      sign_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      ediff_q <= ediff_d;
      sign_q  <= sign_d;
      y_q     <= y_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign y          = y_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed vector table, stall/back-to-back and
// mid-operation reset sequences, and random operands against an integer-division model.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;

  fdiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .x1        (x1),
    .x2        (x2),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_y;
    bit          special;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Quotient of the 24-bit significands scaled by 2^24, truncated: 25 bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e1, e2, e;
    logic [63:0] num, den, q;
    logic [22:0] man;
    s  = a[31] ^ b[31];
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    if (e2 == 0) return {s, 8'hFF, 23'h0};
    if (e1 == 0) return {s, 31'h0};
    num = {40'h0, 1'b1, a[22:0]} << 24;
    den = {40'h0, 1'b1, b[22:0]};
    q   = num / den;
    if (q >= 64'd16777216) begin
      man = q[23:1];
      e   = e1 - e2 + 127;
    end else begin
      man = q[22:0];
      e   = e1 - e2 + 126;
    end
    if (e <= 0) return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], man};
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
  endfunction

  // All tasks start and end #1 after a rising edge.
  task automatic accept(input string name, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, " ready"}, {31'h0, req_ready}, 32'h1);
    x1 = a; x2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    x1 = $urandom; x2 = $urandom;
  endtask

  task automatic wait_result(input string name, input bit special, input logic [31:0] exp_y);
    int n;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (special) begin
      check({name, " fast lat ok"}, {31'h0, n <= 1}, 32'h1);
      if (n == 0) begin
        @(posedge clk); #1;
      end
      check({name, " valid k+1"}, {31'h0, resp_valid}, 32'h1);
    end else begin
      check({name, " latency"}, n, 32'd25);
    end
    check({name, " y"}, y, exp_y);
  endtask

  task automatic release_resp(input string name);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, " valid drop"}, {31'h0, resp_valid}, 32'h0);
    check({name, " ready back"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y, input bit special);
    accept(name, a, b);
    wait_result(name, special, exp_y);
    release_resp(name);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; x1 = '0; x2 = '0;

    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "six_by_two"});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, "one_third"});
    vecs.push_back('{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, "neg_three"});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "div_zero"});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 1'b1, "zero_num"});
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, "underflow"});
    vecs.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, "overflow"});
    vecs.push_back('{32'h00000000, 32'h80000000, 32'hFF800000, 1'b1, "zero_zero"});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, "exp_ff_num"});

    #1;
    check("rst req_ready", {31'h0, req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst y", y, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp_y, vecs[i].special);

    // Stall in DONE, then back-to-back request on the release edge.
    accept("stall", 32'h40C00000, 32'h40000000);
    wait_result("stall", 1'b0, 32'h40400000);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x1 = $urandom; x2 = $urandom;
      @(posedge clk); #1;
      check("stall y", y, 32'h40400000);
      check("stall valid", {31'h0, resp_valid}, 32'h1);
      check("stall req_ready", {31'h0, req_ready}, 32'h0);
    end
    x1 = 32'h3F800000; x2 = 32'h40400000;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("b2b valid drop", {31'h0, resp_valid}, 32'h0);
    check("b2b ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    x1 = $urandom; x2 = $urandom;
    check("b2b accepted", {31'h0, req_ready}, 32'h0);
    wait_result("b2b", 1'b0, 32'h3EAAAAAA);
    release_resp("b2b");

    // Reset at DIV cycle 10 aborts the operation.
    accept("abort", 32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort req_ready", {31'h0, req_ready}, 32'h1);
    check("abort resp_valid", {31'h0, resp_valid}, 32'h0);
    check("abort y", y, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort no resp", {31'h0, resp_valid}, 32'h0);
    run_op("after_abort", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if ($urandom_range(7) == 0) a[30:23] = 8'h00;
      if ($urandom_range(7) == 0) b[30:23] = 8'h00;
      run_op($sformatf("rand%0d", i), a, b, ref_div(a, b), is_special(a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
